// File: rtl/fx2_fifo4_stream_tx.sv
// FX2 slave-FIFO transmit path: buffers a byte stream and writes it into FIFO4,
// arbitrating the shared FX2 bus and committing short packets with PKTEND.
module fx2_fifo4_stream_tx #(
    parameter int DEPTH_LOG2   = 4,
    parameter int PKT_BYTES    = 512,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic                  FIFO4_full,
    input  logic                  bus_gnt,
    output logic                  bus_req,
    output logic [1:0]            FIFO_FIFOADR,
    output logic                  FIFO_WR,
    output logic [7:0]            FIFO_DATAOUT,
    output logic                  FIFO_DATAOUT_OE,
    output logic                  FIFO_PKTEND,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int TMR_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [DEPTH_LOG2:0]   LVL_ZERO = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PKT_BYTES - 1);
    localparam logic [TMR_W-1:0]      TMR_ZERO = TMR_W'(0);
    localparam logic [TMR_W-1:0]      TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0]      TMR_MAX  = TMR_W'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TURN   = 2'd1,
        ST_WRITE  = 2'd2,
        ST_PKTEND = 2'd3
    } state_t;

    state_t                state_r, state_s;
    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_r, rptr_r;
    logic [DEPTH_LOG2:0]   level_r, level_after_s;
    logic [CNT_W-1:0]      byte_cnt_r, byte_cnt_inc_s;
    logic [TMR_W-1:0]      timer_r;
    logic                  pend_r, pflush_r;
    logic                  push_s, wr_s, pktend_s, bus_req_s, flush_any_s;

    assign in_ready        = (level_r < LVL_FULL);
    assign push_s          = in_valid & in_ready;
    assign bus_req_s       = (state_r != ST_IDLE) | (level_r != LVL_ZERO) | pend_r;
    assign byte_cnt_inc_s  = (byte_cnt_r == CNT_LAST) ? CNT_ZERO : byte_cnt_r + CNT_ONE;
    assign flush_any_s     = flush | pflush_r;

    assign bus_req         = bus_req_s;
    assign FIFO_FIFOADR    = bus_req_s ? 2'b10 : 2'b00;
    assign FIFO_WR         = wr_s;
    assign FIFO_DATAOUT_OE = wr_s;
    assign FIFO_DATAOUT    = wr_s ? mem_r[rptr_r] : 8'h00;
    assign FIFO_PKTEND     = pktend_s;
    assign level           = level_r;

    // Bus state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and strobe decode; PKTEND is only ever issued for a non-empty packet.
    always_comb begin
        state_s       = state_r;
        wr_s          = 1'b0;
        pktend_s      = 1'b0;
        level_after_s = level_r;
        case (state_r)
            ST_IDLE: begin
                if (bus_req_s && bus_gnt) begin
                    state_s = ST_TURN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (!bus_gnt) begin
                    state_s = ST_IDLE;
                end else if (level_r != LVL_ZERO) begin
                    state_s = ST_WRITE;
                end else if (pend_r && (byte_cnt_r != CNT_ZERO)) begin
                    state_s = ST_PKTEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (!bus_gnt) begin
                    state_s = ST_IDLE;
                end else begin
                    wr_s          = (level_r != LVL_ZERO) & ~FIFO4_full;
                    level_after_s = wr_s ? (level_r - LVL_ONE) : level_r;
                    if (level_after_s != LVL_ZERO) begin
                        state_s = ST_WRITE;
                    end else if (((pend_r && !wr_s) || pflush_r) &&
                                 ((wr_s ? byte_cnt_inc_s : byte_cnt_r) != CNT_ZERO)) begin
                        state_s = ST_PKTEND;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
            end
            ST_PKTEND: begin
                if (byte_cnt_r == CNT_ZERO) begin
                    state_s = ST_IDLE;
                end else if (bus_gnt && !FIFO4_full) begin
                    pktend_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_PKTEND;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Buffer storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= in_data;
        end
    end

    // Buffer pointers and fill level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_r  <= PTR_ZERO;
            rptr_r  <= PTR_ZERO;
            level_r <= LVL_ZERO;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (wr_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            if (push_s && !wr_s) begin
                level_r <= level_r + LVL_ONE;
            end else if (!push_s && wr_s) begin
                level_r <= level_r - LVL_ONE;
            end
        end
    end

    // Packet byte count, idle timer and PKTEND-pending bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt_r <= CNT_ZERO;
            timer_r    <= TMR_ZERO;
            pend_r     <= 1'b0;
            pflush_r   <= 1'b0;
        end else begin
            if (pktend_s) begin
                byte_cnt_r <= CNT_ZERO;
            end else if (wr_s) begin
                byte_cnt_r <= byte_cnt_inc_s;
            end

            if (wr_s || pktend_s || (byte_cnt_r == CNT_ZERO)) begin
                timer_r <= TMR_ZERO;
            end else if ((level_r == LVL_ZERO) && !pend_r && (timer_r != TMR_MAX)) begin
                timer_r <= timer_r + TMR_ONE;
            end

            // A flush seen while bytes are still buffered waits for the drain.
            if (wr_s || pktend_s) begin
                pend_r <= 1'b0;
            end else if ((byte_cnt_r != CNT_ZERO) && (level_r == LVL_ZERO) &&
                         (timer_r == TMR_MAX || flush_any_s)) begin
                pend_r <= 1'b1;
            end

            if (pktend_s) begin
                pflush_r <= 1'b0;
            end else if (flush_any_s) begin
                pflush_r <= (level_r != LVL_ZERO);
            end
        end
    end

endmodule
